// File: rtl/b01_serial_driver.sv
// Bit-serial operand driver and result collector for the 4-bit b01 serial adder.
// Define B01_DRV_CHECK_EN to carry a golden sum with each pair and flag mismatches on res_err.
module b01_serial_driver (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  output logic       line1,
  output logic       line2,
  output logic       frame_sync,
  input  logic       outp,
  input  logic       overflw,
  output logic       res_valid,
  output logic [3:0] res_sum,
  output logic       res_ovf,
  output logic       res_err
);

  typedef enum logic [1:0] {BIT0 = 2'd0, BIT1 = 2'd1, BIT2 = 2'd2, BIT3 = 2'd3} bit_e;

  bit_e       bit_cnt;
  logic [1:0] bit_idx;
  logic [3:0] shift_a;
  logic [3:0] shift_b;
  logic       cur_data;
  logic       hold_full;
  logic [3:0] hold_a;
  logic [3:0] hold_b;
  logic [2:0] sum_acc;
  logic [3:0] pend_sum;
  logic       pend_data;
  logic       accept;
  logic       frame_end;

  assign bit_idx    = bit_cnt;
  assign frame_end  = (bit_cnt == BIT3);
  assign in_ready   = ~hold_full | frame_end;
  assign accept     = in_valid & in_ready;
  assign line1      = shift_a[0];
  assign line2      = shift_b[0];
  assign frame_sync = (bit_cnt == BIT0);

  // Framing never idles: the adder runs back-to-back 4-bit frames, so an empty
  // hold register simply yields an all-zero frame that produces no result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt   <= BIT0;
      shift_a   <= '0;
      shift_b   <= '0;
      cur_data  <= 1'b0;
      hold_full <= 1'b0;
      hold_a    <= '0;
      hold_b    <= '0;
      sum_acc   <= '0;
      pend_sum  <= '0;
      pend_data <= 1'b0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_ovf   <= 1'b0;
    end else begin
      bit_cnt <= bit_e'(bit_idx + 2'd1);

      if (frame_end) begin
        shift_a   <= hold_full ? hold_a : '0;
        shift_b   <= hold_full ? hold_b : '0;
        cur_data  <= hold_full;
        pend_sum  <= {outp, sum_acc};
        pend_data <= cur_data;
      end else begin
        shift_a            <= {1'b0, shift_a[3:1]};
        shift_b            <= {1'b0, shift_b[3:1]};
        sum_acc[bit_idx]   <= outp;
      end

      // A new pair may land in the hold register on the same edge it drains.
      if (accept) begin
        hold_full <= 1'b1;
        hold_a    <= op_a;
        hold_b    <= op_b;
      end else if (frame_end) begin
        hold_full <= 1'b0;
      end

      // overflw carries the previous frame's carry-out only during bit 0.
      if (bit_cnt == BIT0 && pend_data) begin
        res_valid <= 1'b1;
        res_sum   <= pend_sum;
        res_ovf   <= overflw;
      end else begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef B01_DRV_CHECK_EN
  logic [4:0] hold_exp;
  logic [4:0] cur_exp;
  logic [4:0] pend_exp;
  logic       err_q;
  logic       sticky;

  // Golden value travels in lockstep with the hold/shift/pending stages above.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_exp <= '0;
      cur_exp  <= '0;
      pend_exp <= '0;
      err_q    <= 1'b0;
      sticky   <= 1'b0;
    end else begin
      if (accept)
        hold_exp <= {1'b0, op_a} + {1'b0, op_b};
      if (frame_end) begin
        cur_exp  <= hold_full ? hold_exp : '0;
        pend_exp <= cur_exp;
      end
      if (bit_cnt == BIT0)
        err_q <= pend_data && ({overflw, pend_sum} != pend_exp);
      if (overflw && bit_cnt != BIT0)
        sticky <= 1'b1;
    end
  end

  assign res_err = err_q | sticky;
`else
  assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_b01_serial_driver.sv
// Directed bench for b01_serial_driver with a behavioural serial-adder partner.
module tb_b01_serial_driver;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       line1;
  logic       line2;
  logic       frame_sync;
  logic       outp;
  logic       overflw;
  logic       res_valid;
  logic [3:0] res_sum;
  logic       res_ovf;
  logic       res_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n;

`ifdef B01_DRV_CHECK_EN
  localparam logic ERR6 = 1'b1;
`else
  localparam logic ERR6 = 1'b0;
`endif

  b01_serial_driver dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .line1(line1), .line2(line2), .frame_sync(frame_sync),
    .outp(outp), .overflw(overflw), .res_valid(res_valid), .res_sum(res_sum),
    .res_ovf(res_ovf), .res_err(res_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Serial adder partner: carry clears at each frame start, carry-out shown in bit 0.
  logic [1:0] acnt;
  logic       carry;
  logic       ovf_reg;
  logic       inv_outp;
  logic       cin;
  logic       cnext;

  always_comb begin
    cin     = (acnt == 2'd0) ? 1'b0 : carry;
    cnext   = (line1 & line2) | (line1 & cin) | (line2 & cin);
    outp    = line1 ^ line2 ^ cin ^ inv_outp;
    overflw = (acnt == 2'd0) ? ovf_reg : 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acnt    <= '0;
      carry   <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      acnt  <= acnt + 2'd1;
      carry <= cnext;
      if (acnt == 2'd3)
        ovf_reg <= cnext;
    end
  end

  logic [5:0] rq[$];
  always @(negedge clock)
    if (!reset && res_valid)
      rq.push_back({res_err, res_ovf, res_sum});

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_result(input string tag, input logic [3:0] es, input logic eo, input logic ee);
    int k = 0;
    while (res_valid !== 1'b1 && k < 24) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    chk({tag, "_sum"}, {28'd0, res_sum}, {28'd0, es});
    chk({tag, "_ovf"}, {31'd0, res_ovf}, {31'd0, eo});
    chk({tag, "_err"}, {31'd0, res_err}, {31'd0, ee});
  endtask

  logic [3:0] la;
  logic [3:0] lb;
  logic [3:0] pa[5];
  logic [3:0] pb[5];
  logic [5:0] pe[5];
  int         ea[5];

  initial begin
    reset = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; inv_outp = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_line1", {31'd0, line1}, 32'd0);
    chk("rst_line2", {31'd0, line2}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_sum", {28'd0, res_sum}, 32'd0);
    chk("rst_res_err", {31'd0, res_err}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    cyc = 0;

    // 1: idle framing
    for (int i = 0; i < 12; i++) begin
      chk("t1_line1", {31'd0, line1}, 32'd0);
      chk("t1_line2", {31'd0, line2}, 32'd0);
      chk("t1_sync", {31'd0, frame_sync}, (i % 4 == 0) ? 32'd1 : 32'd0);
      chk("t1_res_valid", {31'd0, res_valid}, 32'd0);
      tick();
    end

    // 2: A=3, B=5 with exact latency, bit 0 in cycle 16, result in cycle 21
    in_valid = 1'b1; op_a = 4'd3; op_b = 4'd5;
    chk("t2_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    la = 4'b0011; lb = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      chk("t2_line1", {31'd0, line1}, {31'd0, la[i]});
      chk("t2_line2", {31'd0, line2}, {31'd0, lb[i]});
      chk("t2_sync", {31'd0, frame_sync}, (i == 0) ? 32'd1 : 32'd0);
      tick();
    end
    chk("t2_early_valid", {31'd0, res_valid}, 32'd0);
    tick();
    chk("t2_cycle", cyc, 32'd21);
    chk("t2_valid", {31'd0, res_valid}, 32'd1);
    chk("t2_sum", {28'd0, res_sum}, 32'd8);
    chk("t2_ovf", {31'd0, res_ovf}, 32'd0);
    chk("t2_err", {31'd0, res_err}, 32'd0);
    tick();
    chk("t2_pulse_end", {31'd0, res_valid}, 32'd0);

    // 3: 9+8 then F+1 back-to-back (second accepted while hold drains)
    in_valid = 1'b1; op_a = 4'h9; op_b = 4'h8;
    chk("t3_ready0", {31'd0, in_ready}, 32'd1);
    tick();
    op_a = 4'hF; op_b = 4'h1;
    chk("t3_ready1", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    wait_result("t3a", 4'd1, 1'b1, 1'b0);
    chk("t3a_cycle", cyc, 32'd29);
    tick();
    wait_result("t3b", 4'd0, 1'b1, 1'b0);
    chk("t3b_cycle", cyc, 32'd33);
    tick();

    // 4: five pairs with in_valid held high
    rq.delete();
    pa = '{4'h1, 4'h7, 4'h8, 4'hA, 4'h6};
    pb = '{4'h2, 4'h7, 4'h8, 4'h7, 4'h3};
    pe = '{6'h03, 6'h0E, 6'h10, 6'h11, 6'h09};
    ea = '{34, 35, 39, 43, 47};
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      op_a = pa[k]; op_b = pb[k];
      n = 0;
      while (!in_ready && n < 8) begin
        tick();
        n++;
      end
      chk("t4_accept_cycle", cyc, ea[k]);
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (rq.size() < 5 && n < 40) begin
      tick();
      n++;
    end
    chk("t4_count", rq.size(), 32'd5);
    for (int k = 0; k < 5; k++)
      chk("t4_result", {26'd0, rq[k]}, {26'd0, pe[k]});

    // 5: reset during bit 2 of a data frame
    while (cyc % 4 != 0) tick();
    rq.delete();
    in_valid = 1'b1; op_a = 4'h5; op_b = 4'h6;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("t5_rst_line1", {31'd0, line1}, 32'd0);
    chk("t5_rst_sync", {31'd0, frame_sync}, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    cyc = 0;
    in_valid = 1'b1; op_a = 4'h7; op_b = 4'h4;
    tick();
    in_valid = 1'b0;
    wait_result("t5", 4'hB, 1'b0, 1'b0);
    chk("t5_cycle", cyc, 32'd9);
    #5;
    chk("t5_count", rq.size(), 32'd1);
    tick();

    // 6: corrupt bit 0 of the 2+2 frame for one cycle, then a clean 3+3
    while (cyc % 4 != 0) tick();
    in_valid = 1'b1; op_a = 4'h2; op_b = 4'h2;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    inv_outp = 1'b1;
    tick();
    inv_outp = 1'b0;
    wait_result("t6_bad", 4'd5, 1'b0, ERR6);
    tick();
    in_valid = 1'b1; op_a = 4'h3; op_b = 4'h3;
    tick();
    in_valid = 1'b0;
    wait_result("t6_good", 4'd6, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
